// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ==========================================================================
// muldiv_seq_if : request/response bundle between the EXU and muldiv_seq
// Revision      : 1.0
// ==========================================================================
interface muldiv_seq_if #(
  parameter int XLEN = 64,
  parameter int OP_W = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] md_op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, md_op, src1, src2, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, md_op, src1, src2, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ==========================================================================
// muldiv_seq : iterative radix-2 RV64M multiply/divide sequencer
// Revision   : 1.0
// ==========================================================================
module muldiv_seq #(
  parameter int XLEN = 64,
  parameter int OP_W = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  muldiv_seq_if.slave bus
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [OP_W-1:0] C_OP_MUL    = OP_W'(0);
  localparam logic [OP_W-1:0] C_OP_MULH   = OP_W'(1);
  localparam logic [OP_W-1:0] C_OP_MULHSU = OP_W'(2);
  localparam logic [OP_W-1:0] C_OP_MULHU  = OP_W'(3);
  localparam logic [OP_W-1:0] C_OP_DIV    = OP_W'(4);
  localparam logic [OP_W-1:0] C_OP_DIVU   = OP_W'(5);
  localparam logic [OP_W-1:0] C_OP_REM    = OP_W'(6);
  localparam logic [OP_W-1:0] C_OP_REMU   = OP_W'(7);
  localparam logic [OP_W-1:0] C_OP_MULW   = OP_W'(8);
  localparam logic [OP_W-1:0] C_OP_DIVW   = OP_W'(9);
  localparam logic [OP_W-1:0] C_OP_DIVUW  = OP_W'(10);
  localparam logic [OP_W-1:0] C_OP_REMW   = OP_W'(11);
  localparam logic [OP_W-1:0] C_OP_REMUW  = OP_W'(12);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             mul_q, mul_d;
  logic             w_q, w_d;
  logic             rem_q, rem_d;
  logic             high_q, high_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;

  // ---------------------------------------------------------------- decode
  logic w_is_w, w_is_mul, w_is_div, w_is_rem, w_is_high, w_rsvd;
  logic w_s1_sgn, w_s2_sgn;

  always_comb begin
    w_is_w    = 1'b0;
    w_is_mul  = 1'b0;
    w_is_div  = 1'b0;
    w_is_rem  = 1'b0;
    w_is_high = 1'b0;
    w_rsvd    = 1'b0;
    w_s1_sgn  = 1'b0;
    w_s2_sgn  = 1'b0;
    case (bus.md_op)
      C_OP_MUL:    begin w_is_mul = 1'b1; w_s1_sgn = 1'b1; w_s2_sgn = 1'b1; end
      C_OP_MULH:   begin w_is_mul = 1'b1; w_is_high = 1'b1; w_s1_sgn = 1'b1; w_s2_sgn = 1'b1; end
      C_OP_MULHSU: begin w_is_mul = 1'b1; w_is_high = 1'b1; w_s1_sgn = 1'b1; end
      C_OP_MULHU:  begin w_is_mul = 1'b1; w_is_high = 1'b1; end
      C_OP_DIV:    begin w_is_div = 1'b1; w_s1_sgn = 1'b1; w_s2_sgn = 1'b1; end
      C_OP_DIVU:   begin w_is_div = 1'b1; end
      C_OP_REM:    begin w_is_div = 1'b1; w_is_rem = 1'b1; w_s1_sgn = 1'b1; w_s2_sgn = 1'b1; end
      C_OP_REMU:   begin w_is_div = 1'b1; w_is_rem = 1'b1; end
      // only the low word of a MULW product is kept, so signedness is irrelevant
      C_OP_MULW:   begin w_is_mul = 1'b1; w_is_w = 1'b1; end
      C_OP_DIVW:   begin w_is_div = 1'b1; w_is_w = 1'b1; w_s1_sgn = 1'b1; w_s2_sgn = 1'b1; end
      C_OP_DIVUW:  begin w_is_div = 1'b1; w_is_w = 1'b1; end
      C_OP_REMW:   begin w_is_div = 1'b1; w_is_w = 1'b1; w_is_rem = 1'b1; w_s1_sgn = 1'b1; w_s2_sgn = 1'b1; end
      C_OP_REMUW:  begin w_is_div = 1'b1; w_is_w = 1'b1; w_is_rem = 1'b1; end
      default:     begin w_rsvd = 1'b1; end
    endcase
  end

  // ------------------------------------------------------ operand prep
  logic [XLEN-1:0] w_a, w_b, w_a_mag, w_b_mag, w_a_res, w_min, w_spec_res;
  logic            w_a_neg, w_b_neg, w_div_zero, w_ovf;

  assign w_a = w_is_w ? {{HALF{w_s1_sgn & bus.src1[HALF-1]}}, bus.src1[HALF-1:0]} : bus.src1;
  assign w_b = w_is_w ? {{HALF{w_s2_sgn & bus.src2[HALF-1]}}, bus.src2[HALF-1:0]} : bus.src2;

  assign w_a_neg = w_s1_sgn & w_a[XLEN-1];
  assign w_b_neg = w_s2_sgn & w_b[XLEN-1];
  assign w_a_mag = w_a_neg ? (~w_a + XLEN'(1)) : w_a;
  assign w_b_mag = w_b_neg ? (~w_b + XLEN'(1)) : w_b;

  // Dividend as it must appear in a result: W ops always sign-extend the low word
  assign w_a_res = w_is_w ? {{HALF{bus.src1[HALF-1]}}, bus.src1[HALF-1:0]} : bus.src1;
  assign w_min   = w_is_w ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};

  assign w_div_zero = w_is_div & (w_b == '0);
  assign w_ovf      = w_is_div & w_s1_sgn & (w_a == w_min) & (w_b == '1);

  always_comb begin
    if (w_rsvd)
      w_spec_res = '0;
    else if (w_div_zero)
      w_spec_res = w_is_rem ? w_a_res : '1;
    else
      w_spec_res = w_is_rem ? '0 : w_a_res;
  end

  // ------------------------------------------------------ iteration steps
  logic [XLEN:0] w_sum, w_shift, w_trial;

  assign w_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  assign w_shift = {hi_q, lo_q[XLEN-1]};
  assign w_trial = w_shift - {1'b0, opnd_q};

  // ------------------------------------------------------ sign fix / select
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quo_s, w_rem_s, w_div_sel, w_fix_res;

  assign w_prod    = {hi_q, lo_q};
  assign w_prod_s  = neg_res_q ? (~w_prod + (2*XLEN)'(1)) : w_prod;
  assign w_quo_s   = neg_res_q ? (~lo_q + XLEN'(1)) : lo_q;
  assign w_rem_s   = neg_rem_q ? (~hi_q + XLEN'(1)) : hi_q;
  assign w_div_sel = rem_q ? w_rem_s : w_quo_s;

  always_comb begin
    if (mul_q) begin
      // a 32-iteration multiply leaves the product shifted up by HALF bits
      if (w_q)
        w_fix_res = {{HALF{lo_q[XLEN-1]}}, lo_q[XLEN-1:HALF]};
      else if (high_q)
        w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      else
        w_fix_res = w_prod_s[XLEN-1:0];
    end else begin
      w_fix_res = w_q ? {{HALF{w_div_sel[HALF-1]}}, w_div_sel[HALF-1:0]} : w_div_sel;
    end
  end

  // ------------------------------------------------------ next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    mul_d     = mul_q;
    w_d       = w_q;
    rem_d     = rem_q;
    high_d    = high_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;

    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            mul_d     = w_is_mul;
            w_d       = w_is_w;
            rem_d     = w_is_rem;
            high_d    = w_is_high;
            neg_res_d = w_a_neg ^ w_b_neg;
            neg_rem_d = w_a_neg;
            if (w_rsvd || w_div_zero || w_ovf) begin
              result_d = w_spec_res;
              state_d  = S_DONE;
            end else begin
              state_d = S_CALC;
              cnt_d   = w_is_w ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
              hi_d    = '0;
              if (w_is_mul) begin
                lo_d   = w_b_mag;
                opnd_d = w_a_mag;
              end else begin
                // W dividends sit in the top half so their MSB shifts out first
                lo_d   = w_is_w ? {w_a_mag[HALF-1:0], {HALF{1'b0}}} : w_a_mag;
                opnd_d = w_b_mag;
              end
            end
          end
        end
        S_CALC: begin
          if (mul_q) begin
            hi_d = w_sum[XLEN:1];
            lo_d = {w_sum[0], lo_q[XLEN-1:1]};
          end else if (!w_trial[XLEN]) begin
            hi_d = w_trial[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = w_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0)
            state_d = S_FIX;
        end
        S_FIX: begin
          result_d = w_fix_res;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready)
            state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------ registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      mul_q     <= 1'b0;
      w_q       <= 1'b0;
      rem_q     <= 1'b0;
      high_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      mul_q     <= mul_d;
      w_q       <= w_d;
      rem_q     <= rem_d;
      high_q    <= high_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ==========================================================================
// tb_muldiv_seq : scoreboard bench for muldiv_seq
// Revision      : 1.0
// ==========================================================================
module tb_muldiv_seq;

  localparam int XLEN = 64;
  localparam int OP_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(XLEN), .OP_W(OP_W)) bus ();

  muldiv_seq #(.XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // edges: clock edges after the accept edge before out_valid is seen
  typedef struct {
    logic [63:0] res;
    int          edges;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_bad = 0;
  logic [63:0] last_res = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=0x%016h want=0x%016h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [31:0] a32, b32;
    logic [31:0]        ua, ub;
    a32 = a[31:0];
    b32 = b[31:0];
    ua  = a[31:0];
    ub  = b[31:0];
    case (op)
      4'd0: return a * b;
      4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
      4'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
      4'd4: begin
        if (b == 64'd0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        return $signed(a) / $signed(b);
      end
      4'd5: return (b == 64'd0) ? '1 : a / b;
      4'd6: begin
        if (b == 64'd0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
        return $signed(a) % $signed(b);
      end
      4'd7: return (b == 64'd0) ? a : a % b;
      4'd8: return sx32(ua * ub);
      4'd9: begin
        if (b32 == 0) return '1;
        if (a32 == 32'sh8000_0000 && b32 == -32'sd1) return sx32(ua);
        return sx32(a32 / b32);
      end
      4'd10: return (ub == 32'd0) ? '1 : sx32(ua / ub);
      4'd11: begin
        if (b32 == 0) return sx32(ua);
        if (a32 == 32'sh8000_0000 && b32 == -32'sd1) return 64'd0;
        return sx32(a32 % b32);
      end
      4'd12: return (ub == 32'd0) ? sx32(ua) : sx32(ua % ub);
      default: return 64'd0;
    endcase
  endfunction

  function automatic int model_edges(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op > 4'd12) return 0;
    if (op inside {4'd4, 4'd5, 4'd6, 4'd7} && b == 64'd0) return 0;
    if (op inside {4'd4, 4'd6} && a == 64'h8000_0000_0000_0000 && b == '1) return 0;
    if (op inside {4'd9, 4'd10, 4'd11, 4'd12} && b[31:0] == 32'd0) return 0;
    if (op inside {4'd9, 4'd11} && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 0;
    return (op >= 4'd8) ? 33 : 65;
  endfunction

  // Drives one request from IDLE; returns just after the accept edge
  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.md_op    = op;
    bus.src1     = a;
    bus.src2     = b;
    e.res        = model(op, a, b);
    e.edges      = model_edges(op, a, b);
    exp_q.push_back(e);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic score(input string tag, input int n);
    exp_t e;
    e = exp_q.pop_front();
    check({tag, " valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, " lat"}, 64'(n), 64'(e.edges));
    check({tag, " res"}, bus.result, e.res);
    last_res = e.res;
  endtask

  task automatic handoff();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int n;
    send(op, a, b);
    wait_out(n);
    score(tag, n);
    handoff();
  endtask

  logic [3:0]  d_op [14] = '{4'd0, 4'd3, 4'd4, 4'd6, 4'd5, 4'd6, 4'd9, 4'd8,
                             4'd1, 4'd2, 4'd12, 4'd13, 4'd9, 4'd10};
  logic [63:0] d_a  [14] = '{64'd7, 64'd7, -64'sd20, -64'sd20, 64'd99,
                             64'h8000_0000_0000_0000, 64'h1_0000_0010, 64'h7FFF_FFFF,
                             64'h8000_0000_0000_0000, -64'sd1, 64'hABCD_0000_8765_4321,
                             64'd55, 64'h8000_0000, 64'hFFFF_FFF0};
  logic [63:0] d_b  [14] = '{-64'sd3, -64'sd3, 64'd6, 64'd6, 64'd0, -64'sd1, 64'd3, 64'd2,
                             64'h8000_0000_0000_0000, 64'd5, 64'h1_0000_0000,
                             64'd3, 64'hFFFF_FFFF, 64'd7};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int hits;
    logic [63:0] ra, rb;
    logic [3:0]  rop;

    bus.in_valid  = 1'b0;
    bus.md_op     = '0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    #2 rst = 1'b1;
    repeat (3) tick();
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst result", bus.result, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++)
      run($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i]);

    for (int i = 0; i < 16; i++) begin
      rop = 4'($urandom_range(0, 12));
      ra  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = 64'($urandom_range(0, 9));
        1:       rb = 64'($urandom);
        default: rb = {$urandom, $urandom};
      endcase
      run($sformatf("rnd%0d", i), rop, ra, rb);
    end

    // backpressure in DONE, then a request already waiting at the handoff edge
    send(4'd5, 64'd100, 64'd7);
    wait_out(n);
    score("bp", n);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp hold res", bus.result, last_res);
      check("bp in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b1;
    bus.md_op     = 4'd0;
    bus.src1      = 64'd3;
    bus.src2      = 64'd4;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp idle out_valid", 64'(bus.out_valid), 64'd0);
    check("bp no shared accept", 64'(bus.busy), 64'd0);
    send(4'd0, 64'd3, 64'd4);
    check("bp accepted", 64'(bus.busy), 64'd1);
    wait_out(n);
    score("bp next", n);
    handoff();

    // flush in the middle of CALC
    send(4'd1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    repeat (20) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    void'(exp_q.pop_back());
    check("flush busy", 64'(bus.busy), 64'd0);
    check("flush in_ready", 64'(bus.in_ready), 64'd1);
    check("flush out_valid", 64'(bus.out_valid), 64'd0);
    check("flush result kept", bus.result, last_res);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush blocks accept", 64'(bus.busy), 64'd0);
    hits = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.out_valid) hits++;
    end
    check("flush quiet", 64'(hits), 64'd0);

    // asynchronous reset mid-CALC
    send(4'd4, -64'sd1000, 64'd7);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("arst in_ready", 64'(bus.in_ready), 64'd1);
    check("arst out_valid", 64'(bus.out_valid), 64'd0);
    check("arst busy", 64'(bus.busy), 64'd0);
    check("arst result", bus.result, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run("post rst", 4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);

    check("queue drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
